// File: rtl/led_pkg.sv
// Shared constants for the LED breathing output stage.
// Mode encodings and default PWM / prescaler sizing.
package led_pkg;

  localparam logic [1:0] LED_MODE_OFF     = 2'b00;
  localparam logic [1:0] LED_MODE_CNT     = 2'b01;
  localparam logic [1:0] LED_MODE_BREATHE = 2'b10;
  localparam logic [1:0] LED_MODE_CHASE   = 2'b11;

  localparam int LED_PWM_BITS    = 8;
  localparam int LED_STEP_CYCLES = 390625;

endpackage

// File: rtl/led_tri_duty.sv
// Phase plus offset folded into a triangle-wave duty value.
// Top half of the phase circle mirrors the bottom half.
module led_tri_duty
  import led_pkg::*;
#(
  parameter int PWM_BITS = LED_PWM_BITS
) (
  input  logic [PWM_BITS:0]   phase,
  input  logic [PWM_BITS:0]   offset,
  output logic [PWM_BITS-1:0] duty
);

  logic [PWM_BITS:0] p;

  always_comb begin
    p    = phase + offset;
    duty = p[PWM_BITS] ? ~p[PWM_BITS-1:0]
                       :  p[PWM_BITS-1:0];
  end

endmodule

// File: rtl/led_breathe.sv
// LED output stage: off, counter pass-through,
// breathing and quarter-period chase breathing.
module led_breathe
  import led_pkg::*;
#(
  parameter int PWM_BITS    = LED_PWM_BITS,
  parameter int STEP_CYCLES = LED_STEP_CYCLES,
  parameter int NUM_LEDS    = 4
) (
  input  logic                Clk_i,
  input  logic                Nreset_i,
  input  logic                Enable_i,
  input  logic [1:0]          Mode_i,
  input  logic [3:0]          Cnt_i,
  output logic [NUM_LEDS-1:0] Led_o,
  output logic                Step_o
);

  localparam int SW = $clog2(STEP_CYCLES);
  localparam logic [SW-1:0] STEP_LAST =
    SW'(STEP_CYCLES - 1);

  logic [1:0]          mode_q;
  logic [SW-1:0]       step_ctr;
  logic [PWM_BITS:0]   phase;
  logic [PWM_BITS-1:0] pwm_ctr;
  logic                mode_chg;
  logic                active;
  logic                tick;
  logic [NUM_LEDS-1:0] pwm_lit;
  logic [NUM_LEDS-1:0] led_d;

  assign mode_chg = (Mode_i != mode_q);
  assign active   = Enable_i & mode_q[1];
  assign tick     = active & (step_ctr == STEP_LAST);

  always_ff @(posedge Clk_i or negedge Nreset_i) begin
    if (!Nreset_i) begin
      mode_q   <= LED_MODE_OFF;
      step_ctr <= '0;
      phase    <= '0;
    end else begin
      mode_q <= Mode_i;
      // A mode switch restarts the ramp even if a step fires now
      if (mode_chg) begin
        step_ctr <= '0;
        phase    <= '0;
      end else if (active) begin
        step_ctr <= tick ? '0 : step_ctr + 1'b1;
        if (tick)
          phase <= phase + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_i or negedge Nreset_i) begin
    if (!Nreset_i)
      pwm_ctr <= '0;
    else if (Enable_i)
      pwm_ctr <= pwm_ctr + 1'b1;
  end

  for (genvar k = 0; k < NUM_LEDS; k++) begin : g_led
    localparam logic [PWM_BITS:0] OFS =
      (PWM_BITS+1)'(k * (2 ** (PWM_BITS - 1)));
    logic [PWM_BITS:0]   offset;
    logic [PWM_BITS-1:0] duty;

    assign offset = Mode_i[0] ? OFS : '0;

    led_tri_duty #(
      .PWM_BITS(PWM_BITS)
    ) u_duty (
      .phase (phase),
      .offset(offset),
      .duty  (duty)
    );

    assign pwm_lit[k] = (pwm_ctr < duty);
  end

  always_comb begin
    led_d = '0;
    unique case (1'b1)
      !Enable_i:
        led_d = '0;
      Enable_i && (Mode_i == LED_MODE_CNT):
        led_d = NUM_LEDS'(Cnt_i);
      Enable_i && Mode_i[1]:
        led_d = pwm_lit;
      default:
        led_d = '0;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Nreset_i) begin
    if (!Nreset_i) begin
      Led_o  <= '0;
      Step_o <= 1'b0;
    end else begin
      Led_o  <= led_d;
      Step_o <= tick;
    end
  end

endmodule

// File: tb/tb_led_breathe.sv
// Bench for led_breathe with a count-based reference model.
// Small prescaler so full phase wraps fit in a short run.
module tb_led_breathe;

  localparam int S = 4;

  logic       Clk_i;
  logic       Nreset_i;
  logic       Enable_i;
  logic [1:0] Mode_i;
  logic [3:0] Cnt_i;
  logic [3:0] Led_o;
  logic       Step_o;

  int checks = 0;
  int errors = 0;

  led_breathe #(
    .PWM_BITS(8),
    .STEP_CYCLES(S),
    .NUM_LEDS(4)
  ) dut (
    .Clk_i   (Clk_i),
    .Nreset_i(Nreset_i),
    .Enable_i(Enable_i),
    .Mode_i  (Mode_i),
    .Cnt_i   (Cnt_i),
    .Led_o   (Led_o),
    .Step_o  (Step_o)
  );

  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  // Model: m_t = active cycles since last clear, m_e = enabled cycles
  logic [1:0] m_mq;
  int         m_t;
  int         m_e;
  int         m_ph;
  logic [3:0] m_led;
  logic       m_step;
  logic       m_chg;
  logic       m_act;

  assign m_ph  = (m_t / S) % 512;
  assign m_chg = (Mode_i != m_mq);
  assign m_act = Enable_i && m_mq[1];

  function automatic logic [3:0] exp_led(
    input logic en, input logic [1:0] md,
    input logic [3:0] cnt, input int pwm, input int ph);
    logic [3:0] r;
    int p, d;
    r = 4'b0;
    for (int k = 0; k < 4; k++) begin
      p = (ph + ((md == 2'b11) ? k * 128 : 0)) % 512;
      d = (p < 256) ? p : 511 - p;
      r[k] = (pwm < d);
    end
    if (!en || md == 2'b00) r = 4'b0;
    else if (md == 2'b01) r = cnt;
    return r;
  endfunction

  always @(posedge Clk_i or negedge Nreset_i) begin
    if (!Nreset_i) begin
      m_mq <= 2'b00; m_t <= 0; m_e <= 0;
      m_led <= 4'b0; m_step <= 1'b0;
    end else begin
      m_mq   <= Mode_i;
      m_t    <= m_chg ? 0 : (m_act ? m_t + 1 : m_t);
      m_e    <= Enable_i ? m_e + 1 : m_e;
      m_step <= m_act && (m_t % S == S - 1);
      m_led  <= exp_led(Enable_i, Mode_i, Cnt_i,
                        m_e % 256, m_ph);
    end
  end

  task automatic test_reset();
    int n;
    bit seen;
    Enable_i = 1'b1; Mode_i = 2'b11;
    repeat (37) @(negedge Clk_i);
    #2 Nreset_i = 1'b0;
    #1;
    checks++;
    if (Led_o !== 4'b0) begin
      errors++;
      $display("FAIL reset_led got %b want 0000", Led_o);
    end
    checks++;
    if (Step_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_step got %b want 0", Step_o);
    end
    @(negedge Clk_i);
    Nreset_i = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge Clk_i);
      n++;
      checks++;
      if (Led_o !== m_led || Step_o !== m_step) begin
        errors++;
        $display("FAIL reset_run led %b/%b step %b/%b",
                 Led_o, m_led, Step_o, m_step);
      end
      if (Step_o === 1'b1) seen = 1;
    end
    checks++;
    if (n != S + 1) begin
      errors++;
      $display("FAIL first_step at cycle %0d want %0d",
               n, S + 1);
    end
  endtask

  task automatic test_pass();
    logic [3:0] c;
    Mode_i = 2'b01;
    @(negedge Clk_i);
    Cnt_i = 4'b1010;
    @(negedge Clk_i);
    checks++;
    if (Led_o !== 4'b1010) begin
      errors++;
      $display("FAIL pass_1010 got %b want 1010", Led_o);
    end
    Cnt_i = 4'b0101;
    @(negedge Clk_i);
    checks++;
    if (Led_o !== 4'b0101) begin
      errors++;
      $display("FAIL pass_0101 got %b want 0101", Led_o);
    end
    for (int i = 0; i < 24; i++) begin
      c = 4'($urandom);
      Cnt_i = c;
      Mode_i = (i < 16) ? 2'b01 : 2'b00;
      @(negedge Clk_i);
      checks++;
      if (Led_o !== ((i < 16) ? c : 4'b0)) begin
        errors++;
        $display("FAIL pass_rand i=%0d got %b cnt %b",
                 i, Led_o, c);
      end
    end
  endtask

  task automatic window(input string nm, input int len);
    int hi [4];
    int mh [4];
    for (int k = 0; k < 4; k++) begin
      hi[k] = 0; mh[k] = 0;
    end
    for (int i = 0; i < len; i++) begin
      @(negedge Clk_i);
      for (int k = 0; k < 4; k++) begin
        hi[k] += int'(Led_o[k]);
        mh[k] += int'(m_led[k]);
      end
      checks++;
      if (Led_o !== m_led || Step_o !== m_step) begin
        errors++;
        $display("FAIL %s cyc %0d led %b/%b step %b/%b",
                 nm, i, Led_o, m_led, Step_o, m_step);
      end
      if (Mode_i == 2'b10) begin
        checks++;
        if (Led_o !== {4{Led_o[0]}}) begin
          errors++;
          $display("FAIL %s_equal got %b", nm, Led_o);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (hi[k] != mh[k]) begin
        errors++;
        $display("FAIL %s_count led%0d got %0d want %0d",
                 nm, k, hi[k], mh[k]);
      end
    end
  endtask

  task automatic test_breathe();
    Enable_i = 1'b1; Mode_i = 2'b10;
    window("breathe_ramp", 512);
    window("breathe_win", 256);
  endtask

  task automatic test_chase();
    int ph_b;
    Mode_i = 2'b11;
    @(negedge Clk_i);
    for (int i = 0; i < 2 * S; i++) begin
      ph_b = m_ph;
      @(negedge Clk_i);
      checks++;
      if (ph_b == 0 && Led_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL chase_duty0 got %b want 0", Led_o[0]);
      end
    end
    window("chase_win", 256);
  endtask

  task automatic test_wrap();
    int n, ph_b, last, gap;
    Mode_i = 2'b10;
    n = 0;
    while (m_ph != 508 && n < 3000) begin
      @(negedge Clk_i);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL wrap_timeout cycles %0d", n);
    end
    last = -1;
    for (int i = 0; i < 12 * S; i++) begin
      ph_b = m_ph;
      @(negedge Clk_i);
      checks++;
      if (Led_o !== m_led) begin
        errors++;
        $display("FAIL wrap_led got %b want %b", Led_o, m_led);
      end
      if (ph_b == 511 || ph_b == 0) begin
        checks++;
        if (Led_o[0] !== 1'b0) begin
          errors++;
          $display("FAIL wrap_dark ph %0d got %b want 0",
                   ph_b, Led_o[0]);
        end
      end
      if (Step_o === 1'b1) begin
        gap = i - last;
        if (last >= 0) begin
          checks++;
          if (gap != S) begin
            errors++;
            $display("FAIL wrap_step gap %0d want %0d", gap, S);
          end
        end
        last = i;
      end
    end
  endtask

  task automatic test_freeze();
    int len;
    Mode_i = 2'b10;
    window("pre_freeze", 300);
    Enable_i = 1'b0;
    len = 100 + int'($urandom_range(0, 7));
    for (int i = 0; i < len; i++) begin
      @(negedge Clk_i);
      checks++;
      if (Led_o !== 4'b0 || Step_o !== 1'b0) begin
        errors++;
        $display("FAIL freeze led %b step %b want 0",
                 Led_o, Step_o);
      end
    end
    Enable_i = 1'b1;
    window("resume", 200);
    Mode_i = 2'b11;
    window("mode_clear", 256);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) Mode_i = 2'($urandom);
      if ($urandom_range(0, 99) < 2) Enable_i = ~Enable_i;
      Cnt_i = 4'($urandom);
      @(negedge Clk_i);
      checks++;
      if (Led_o !== m_led || Step_o !== m_step) begin
        errors++;
        $display("FAIL rand cyc %0d led %b/%b step %b/%b",
                 i, Led_o, m_led, Step_o, m_step);
      end
    end
  endtask

  initial begin
    Nreset_i = 1'b0; Enable_i = 1'b0;
    Mode_i = 2'b00; Cnt_i = 4'b0;
    repeat (3) @(negedge Clk_i);
    Nreset_i = 1'b1;
    test_reset();
    test_pass();
    test_breathe();
    test_chase();
    test_wrap();
    test_freeze();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
